// File: rtl/procesador_armv4_multiciclo.sv
// Multicycle ARMv4-subset core: one shared ALU, one unified req/ready memory port.
// Latency: data-proc 4, LDR 5, STR 4, B/BL 3, cond-fail 2 cycles with zero-wait memory.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold address/data until mem_ready; optional timeout halts.
module procesador_armv4_multiciclo #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       pc,
  output logic [15:0][31:0] leds_registers,
  output logic [3:0]        state_dbg,
  output logic              halted,
  output logic              bus_error
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXECUTE  = 4'd2;
  localparam logic [3:0] S_ALUWB    = 4'd3;
  localparam logic [3:0] S_MEMADDR  = 4'd4;
  localparam logic [3:0] S_MEMREAD  = 4'd5;
  localparam logic [3:0] S_MEMWB    = 4'd6;
  localparam logic [3:0] S_MEMWRITE = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_HALT     = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_ORR = 2'd3;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  // Architectural and inter-state registers
  logic [3:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [3:0]  nzcv_q;
  logic [31:0] regs_q [0:14];
  logic [31:0] a_q, b_q, d_q;
  logic [31:0] res_q;
  logic [3:0]  flg_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] wait_q;
  logic        bus_err_q;

  // Instruction fields
  logic [3:0]  f_cond, f_cmd, f_rn, f_rd, f_rm, f_rot;
  logic [1:0]  f_op;
  logic        f_i, f_s, f_u, f_l, f_bl;
  logic [7:0]  f_imm8;
  logic [11:0] f_imm12;
  logic [23:0] f_imm24;

  assign f_cond  = ir_q[31:28];
  assign f_op    = ir_q[27:26];
  assign f_i     = ir_q[25];
  assign f_cmd   = ir_q[24:21];
  assign f_bl    = ir_q[24];
  assign f_u     = ir_q[23];
  assign f_s     = ir_q[20];
  assign f_l     = ir_q[20];
  assign f_rn    = ir_q[19:16];
  assign f_rd    = ir_q[15:12];
  assign f_rot   = ir_q[11:8];
  assign f_imm8  = ir_q[7:0];
  assign f_rm    = ir_q[3:0];
  assign f_imm12 = ir_q[11:0];
  assign f_imm24 = ir_q[23:0];

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  // Register-file read ports; R15 reads as instruction address + 8
  logic [31:0] rn_val, rm_val, rd_val;
  always_comb begin
    rn_val = (f_rn == 4'd15) ? pc_plus4 : regs_q[f_rn];
    rm_val = (f_rm == 4'd15) ? pc_plus4 : regs_q[f_rm];
    rd_val = (f_rd == 4'd15) ? pc_plus4 : regs_q[f_rd];
  end

  // Condition-code evaluation against the current flags
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (f_cond)
      4'h0: cond_pass = nzcv_q[2];
      4'h1: cond_pass = ~nzcv_q[2];
      4'h2: cond_pass = nzcv_q[1];
      4'h3: cond_pass = ~nzcv_q[1];
      4'h4: cond_pass = nzcv_q[3];
      4'h5: cond_pass = ~nzcv_q[3];
      4'h6: cond_pass = nzcv_q[0];
      4'h7: cond_pass = ~nzcv_q[0];
      4'h8: cond_pass = nzcv_q[1] & ~nzcv_q[2];
      4'h9: cond_pass = ~nzcv_q[1] | nzcv_q[2];
      4'hA: cond_pass = (nzcv_q[3] == nzcv_q[0]);
      4'hB: cond_pass = (nzcv_q[3] != nzcv_q[0]);
      4'hC: cond_pass = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
      4'hD: cond_pass = nzcv_q[2] | (nzcv_q[3] != nzcv_q[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Operand2: rotated immediate or Rm (shift field deliberately ignored)
  logic [31:0] imm_rot, op2;
  logic [4:0]  rot_amt;
  always_comb begin
    rot_amt = {f_rot, 1'b0};
    imm_rot = ({24'd0, f_imm8} >> rot_amt) | ({24'd0, f_imm8} << (6'd32 - {1'b0, rot_amt}));
    op2     = f_i ? imm_rot : b_q;
  end

  // Data-processing opcode decode: supported commands and their ALU operation
  logic       cmd_ok;
  logic [1:0] cmd_alu;
  always_comb begin
    cmd_ok  = 1'b1;
    cmd_alu = ALU_ADD;
    case (f_cmd)
      CMD_ADD: cmd_alu = ALU_ADD;
      CMD_SUB: cmd_alu = ALU_SUB;
      CMD_AND: cmd_alu = ALU_AND;
      CMD_ORR: cmd_alu = ALU_ORR;
      CMD_CMP: begin
        cmd_alu = ALU_SUB;
        cmd_ok  = f_s;
      end
      default: cmd_ok = 1'b0;
    endcase
  end

  // Shared ALU: operand selection depends on which state is using it
  logic [31:0] alu_a, alu_b, alu_b_eff, alu_res;
  logic [1:0]  alu_op;
  logic [32:0] alu_sum;
  logic        alu_sub, alu_arith, alu_c, alu_v;
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_a = pc_q;
        alu_b = 32'd4;
      end
      S_EXECUTE: begin
        alu_a  = a_q;
        alu_b  = op2;
        alu_op = cmd_alu;
      end
      S_MEMADDR: begin
        alu_a  = a_q;
        alu_b  = {20'd0, f_imm12};
        alu_op = f_u ? ALU_ADD : ALU_SUB;
      end
      S_BRANCH: begin
        alu_a = pc_plus4;
        alu_b = {{6{f_imm24[23]}}, f_imm24, 2'b00};
      end
      default: ;
    endcase
    alu_sub   = (alu_op == ALU_SUB);
    alu_arith = (alu_op == ALU_ADD) || alu_sub;
    alu_b_eff = alu_sub ? ~alu_b : alu_b;
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b_eff} + {32'd0, alu_sub};
    case (alu_op)
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_ORR: alu_res = alu_a | alu_b;
      default: alu_res = alu_sum[31:0];
    endcase
    alu_c = alu_arith & alu_sum[32];
    alu_v = alu_arith & (alu_a[31] == alu_b_eff[31]) & (alu_sum[31] != alu_a[31]);
  end

  // Memory port: driven from state so address/data stay put while waiting
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
        end
        S_MEMREAD: begin
          mem_req  = 1'b1;
          mem_addr = addr_q;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = d_q;
        end
        default: ;
      endcase
    end
  end

  logic xfer_done, xfer_wait, timeout_hit;
  assign xfer_done   = mem_req & mem_ready;
  assign xfer_wait   = mem_req & ~mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && xfer_wait && (wait_q == TIMEOUT_LAST);

  // Next-state logic of the control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (xfer_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) state_d = S_FETCH;
        else begin
          case (f_op)
            2'b00:   state_d = S_EXECUTE;
            2'b01:   state_d = S_MEMADDR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_HALT;
          endcase
        end
      end
      S_EXECUTE: state_d = cmd_ok ? S_ALUWB : S_HALT;
      S_ALUWB:   state_d = S_FETCH;
      S_MEMADDR: state_d = f_l ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (xfer_done) state_d = S_MEMWB;
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWRITE: begin
        if (timeout_hit)    state_d = S_HALT;
        else if (xfer_done) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // State, datapath registers, register file and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      nzcv_q    <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      d_q       <= 32'd0;
      res_q     <= 32'd0;
      flg_q     <= 4'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      wait_q    <= 32'd0;
      bus_err_q <= 1'b0;
      for (int i = 0; i < 15; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= xfer_wait ? wait_q + 32'd1 : 32'd0;
      if (timeout_hit) bus_err_q <= 1'b1;
      case (state_q)
        S_FETCH: begin
          if (xfer_done) begin
            ir_q <= mem_rdata;
            pc_q <= alu_res;
          end
        end
        S_DECODE: begin
          a_q <= rn_val;
          b_q <= rm_val;
          d_q <= rd_val;
        end
        S_EXECUTE: begin
          res_q <= alu_res;
          flg_q <= {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
        end
        S_ALUWB: begin
          if (f_s) nzcv_q <= flg_q;
          if (f_cmd != CMD_CMP) begin
            if (f_rd == 4'd15) pc_q <= res_q;
            else               regs_q[f_rd] <= res_q;
          end
        end
        S_MEMADDR: addr_q <= {alu_res[31:2], 2'b00};
        S_MEMREAD: begin
          if (xfer_done) data_q <= mem_rdata;
        end
        S_MEMWB: begin
          if (f_rd == 4'd15) pc_q <= data_q;
          else               regs_q[f_rd] <= data_q;
        end
        S_BRANCH: begin
          pc_q <= alu_res;
          if (f_bl) regs_q[14] <= pc_q;
        end
        default: ;
      endcase
    end
  end

  // Debug/LED view of the architectural state
  always_comb begin
    for (int i = 0; i < 15; i++) leds_registers[i] = regs_q[i];
    leds_registers[15] = pc_q;
  end

  assign pc        = pc_q;
  assign state_dbg = state_q;
  assign halted    = (state_q == S_HALT);
  assign bus_error = bus_err_q;

endmodule

// File: tb/tb_procesador_armv4_multiciclo.sv
// Bench for procesador_armv4_multiciclo: directed programs plus random programs
// compared against an instruction-level model (registers, pc, memory, cycle counts).
module tb_procesador_armv4_multiciclo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, rdy, load_req;
  logic [31:0]       rdata;
  logic              mem_req, mem_we, halted, bus_error;
  logic [31:0]       mem_addr, mem_wdata, pc;
  logic [15:0][31:0] leds;
  logic [3:0]        state_dbg;

  logic              to_reset, to_rdy;
  logic [31:0]       to_rdata;
  logic              to_req, to_we, to_halted, to_bus_error;
  logic [31:0]       to_addr, to_wdata, to_pc;
  logic [15:0][31:0] to_leds;
  logic [3:0]        to_state;

  logic [31:0] ram  [0:255];
  logic [31:0] prog [0:255];

  int checks = 0;
  int errors = 0;

  procesador_armv4_multiciclo dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(rdy), .mem_rdata(rdata),
    .pc(pc), .leds_registers(leds), .state_dbg(state_dbg),
    .halted(halted), .bus_error(bus_error)
  );

  procesador_armv4_multiciclo #(.RESET_PC(32'h0000_0040), .TIMEOUT(5)) dut_to (
    .clk(clk), .reset(to_reset),
    .mem_req(to_req), .mem_we(to_we), .mem_addr(to_addr), .mem_wdata(to_wdata),
    .mem_ready(to_rdy), .mem_rdata(to_rdata),
    .pc(to_pc), .leds_registers(to_leds), .state_dbg(to_state),
    .halted(to_halted), .bus_error(to_bus_error)
  );

  assign rdata = ram[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= prog[i];
    end else if (mem_req && mem_we && rdy) begin
      ram[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  // Reset the main core and copy prog into RAM; returns just before cycle 1
  task automatic do_reset();
    reset = 1'b1;
    load_req = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_req = 1'b0;
    reset = 1'b0;
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [31:0] m_r [0:15];
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc;
  logic        m_n, m_z, m_c, m_v, m_halt;
  int          m_cyc;

  function automatic logic [31:0] m_reg(input logic [3:0] i, input logic [31:0] ia);
    return (i == 4'd15) ? ia + 32'd8 : m_r[i];
  endfunction

  function automatic logic [31:0] ror1n(input logic [31:0] x, input int n);
    logic [31:0] y = x;
    for (int k = 0; k < n; k++) y = {y[0], y[31:1]};
    return y;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = prog[i];
    m_pc = 32'd0;
    {m_n, m_z, m_c, m_v} = 4'd0;
    m_halt = 1'b0;
    m_cyc = 0;
  endtask

  task automatic m_step();
    logic [31:0] ins, ia, a, b, res, ea;
    logic [3:0]  cmd, rd;
    logic        pass, c, v;
    longint      sa, sb, sr;
    if (m_halt) return;
    ia = m_pc;
    ins = m_mem[ia[9:2]];
    m_pc = ia + 32'd4;
    case (ins[31:28])
      4'h0: pass = m_z;            4'h1: pass = !m_z;
      4'h2: pass = m_c;            4'h3: pass = !m_c;
      4'h4: pass = m_n;            4'h5: pass = !m_n;
      4'h6: pass = m_v;            4'h7: pass = !m_v;
      4'h8: pass = m_c && !m_z;    4'h9: pass = !m_c || m_z;
      4'hA: pass = (m_n == m_v);   4'hB: pass = (m_n != m_v);
      4'hC: pass = !m_z && (m_n == m_v);
      4'hD: pass = m_z || (m_n != m_v);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    if (!pass) begin
      m_cyc += 2;
      return;
    end
    rd = ins[15:12];
    a = m_reg(ins[19:16], ia);
    case (ins[27:26])
      2'b00: begin
        cmd = ins[24:21];
        b = ins[25] ? ror1n({24'd0, ins[7:0]}, 2 * int'(ins[11:8])) : m_reg(ins[3:0], ia);
        if (!(cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100 ||
              (cmd == 4'b1010 && ins[20]))) begin
          m_halt = 1'b1;
          m_cyc += 3;
          return;
        end
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        v = 1'b0;
        res = 32'd0;
        if (cmd == 4'b0100) begin
          res = a + b;
          c = ((64'(a) + 64'(b)) >> 32) != 64'd0;
          sr = sa + sb;
          v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else if (cmd == 4'b0010 || cmd == 4'b1010) begin
          res = a - b;
          c = (a >= b);
          sr = sa - sb;
          v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end else if (cmd == 4'b0000) begin
          res = a & b;
        end else begin
          res = a | b;
        end
        if (ins[20]) begin
          m_n = res[31];
          m_z = (res == 32'd0);
          m_c = c;
          m_v = v;
        end
        if (cmd != 4'b1010) begin
          if (rd == 4'd15) m_pc = res;
          else             m_r[rd] = res;
        end
        m_cyc += 4;
      end
      2'b01: begin
        ea = ins[23] ? a + {20'd0, ins[11:0]} : a - {20'd0, ins[11:0]};
        ea[1:0] = 2'b00;
        if (ins[20]) begin
          if (rd == 4'd15) m_pc = m_mem[ea[9:2]];
          else             m_r[rd] = m_mem[ea[9:2]];
          m_cyc += 5;
        end else begin
          m_mem[ea[9:2]] = m_reg(rd, ia);
          m_cyc += 4;
        end
      end
      2'b10: begin
        if (ins[24]) m_r[14] = ia + 32'd4;
        m_pc = ia + 32'd8 + {{6{ins[23]}}, ins[23:0], 2'b00};
        m_cyc += 3;
      end
      default: begin
        m_halt = 1'b1;
        m_cyc += 2;
      end
    endcase
  endtask

  function automatic logic [31:0] gen_instr();
    logic [3:0]  cond, cmd, rn, rd;
    logic [11:0] imm;
    logic        ib, sb, ub;
    int          r;
    logic [3:0]  cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    r = int'($urandom_range(0, 99));
    cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
    rd = 4'($urandom_range(0, 14));
    if (r < 65) begin
      ib = 1'($urandom_range(0, 1));
      cmd = cmds[$urandom_range(0, 4)];
      sb = (cmd == 4'b1010) ? 1'b1 : 1'($urandom_range(0, 1));
      rn = 4'($urandom_range(0, 15));
      imm = 12'($urandom_range(0, 4095));
      return {cond, 2'b00, ib, cmd, sb, rn, rd, imm};
    end else if (r < 85) begin
      ub = 1'($urandom_range(0, 1));
      imm = 12'($urandom_range(0, 4095));
      return {cond, 2'b01, 1'b0, 1'b1, ub, 1'b0, 1'b0, 1'b1, 4'hF, rd, imm};
    end else begin
      rd = 4'($urandom_range(0, 15));
      imm = 12'($urandom_range(256, 760));
      return {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, rd, imm};
    end
  endfunction

  // ---------------- directed and random sequence ----------------
  initial begin
    int nwr;
    logic [31:0] waddr, wdat;
    reset = 1'b1;
    to_reset = 1'b1;
    to_rdy = 1'b0;
    to_rdata = 32'd0;
    rdy = 1'b1;
    load_req = 1'b0;
    clear_prog();

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", {30'd0, halted, bus_error}, 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst_led%0d", i), leds[i], 32'd0);

    // ORR R1,R0,#5 ; ADD R2,R1,#3
    prog[0] = 32'hE380_1005;
    prog[1] = 32'hE281_2003;
    do_reset();
    cycles(4);
    chk("t1_r1", leds[1], 32'd5);
    chk("t1_pc4", pc, 32'd4);
    cycles(4);
    chk("t1_r2", leds[2], 32'd8);
    chk("t1_pc8", pc, 32'd8);
    chk("t1_led15", leds[15], 32'd8);

    // Fetch stalled three cycles, then reset in the middle of a wait
    do_reset();
    rdy = 1'b0;
    #1;
    chk("t4_req_c0", {31'd0, mem_req}, 32'd1);
    chk("t4_addr_c0", mem_addr, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_req_c%0d", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("t4_addr_c%0d", k), mem_addr, 32'd0);
    end
    rdy = 1'b1;
    cycles(7);
    chk("t4_r1", leds[1], 32'd5);
    chk("t4_r2_early", leds[2], 32'd0);
    cycles(1);
    chk("t4_r2", leds[2], 32'd8);
    chk("t4_pc", pc, 32'd8);
    rdy = 1'b0;
    cycles(2);
    chk("t5_wait_req", {31'd0, mem_req}, 32'd1);
    chk("t5_wait_addr", mem_addr, 32'd8);
    reset = 1'b1;
    #1;
    chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
    chk("t5_rst_pc", pc, 32'd0);
    chk("t5_rst_r2", leds[2], 32'd0);
    rdy = 1'b1;

    // CMP R0,#0 ; BNE +12 ; ADDEQ R4,R0,#7 with R0=0
    clear_prog();
    prog[0] = 32'hE350_0000;
    prog[1] = 32'h1A00_0001;
    prog[2] = 32'h0280_4007;
    do_reset();
    cycles(6);
    chk("t2a_pc_nt", pc, 32'd8);
    cycles(4);
    chk("t2a_r4_zset", leds[4], 32'd7);
    chk("t2a_pc", pc, 32'd12);

    // ORR R0,R0,#1 ; CMP R0,#0 ; BNE -> 0x14
    clear_prog();
    prog[0] = 32'hE380_0001;
    prog[1] = 32'hE350_0000;
    prog[2] = 32'h1A00_0001;
    do_reset();
    cycles(11);
    chk("t2b_pc_taken", pc, 32'd20);
    chk("t2b_r0", leds[0], 32'd1);

    // ORR R2,R0,#8 ; STR R2,[R0,#16] ; LDR R3,[R0,#16]
    clear_prog();
    prog[0] = 32'hE380_2008;
    prog[1] = 32'hE580_2010;
    prog[2] = 32'hE590_3010;
    do_reset();
    nwr = 0;
    waddr = 32'd0;
    wdat = 32'd0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        nwr++;
        waddr = mem_addr;
        wdat = mem_wdata;
      end
    end
    chk("t3_nwrites", 32'(nwr), 32'd1);
    chk("t3_waddr", waddr, 32'd16);
    chk("t3_wdata", wdat, 32'd8);
    chk("t3_r3", leds[3], 32'd8);
    chk("t3_ram", ram[4], 32'd8);
    chk("t3_pc", pc, 32'd12);

    // B 0x20 ; BL +0x100 at 0x20 ; undefined op at 0x128
    clear_prog();
    prog[0]  = 32'hEA00_0006;
    prog[8]  = 32'hEB00_0040;
    prog[74] = 32'hEC00_0000;
    do_reset();
    cycles(3);
    chk("t6_b_pc", pc, 32'h20);
    cycles(3);
    chk("t6_bl_lr", leds[14], 32'h24);
    chk("t6_bl_pc", pc, 32'h128);
    cycles(2);
    chk("t6_undef_halt", {31'd0, halted}, 32'd1);
    chk("t6_undef_pc", pc, 32'h12C);
    cycles(5);
    chk("t6_stay_halt", {31'd0, halted}, 32'd1);
    chk("t6_halt_req", {31'd0, mem_req}, 32'd0);
    chk("t6_lr_kept", leds[14], 32'h24);
    chk("t6_r0_kept", leds[0], 32'd0);
    chk("t6_no_buserr", {31'd0, bus_error}, 32'd0);

    // CMP without S bit is rejected
    clear_prog();
    prog[0] = 32'hE340_0000;
    do_reset();
    cycles(2);
    chk("cmp_s0_running", {31'd0, halted}, 32'd0);
    cycles(1);
    chk("cmp_s0_halt", {31'd0, halted}, 32'd1);

    // Bus timeout on the TIMEOUT=5 instance, memory never ready
    #1;
    chk("to_rst_req", {31'd0, to_req}, 32'd0);
    chk("to_rst_pc", to_pc, 32'h40);
    @(negedge clk);
    to_reset = 1'b0;
    cycles(4);
    chk("to_req_c4", {31'd0, to_req}, 32'd1);
    chk("to_addr_c4", to_addr, 32'h40);
    chk("to_halt_c4", {31'd0, to_halted}, 32'd0);
    cycles(1);
    chk("to_halt_c5", {31'd0, to_halted}, 32'd1);
    chk("to_buserr_c5", {31'd0, to_bus_error}, 32'd1);
    chk("to_req_c5", {31'd0, to_req}, 32'd0);
    to_reset = 1'b1;
    #1;
    chk("to_rst_buserr", {31'd0, to_bus_error}, 32'd0);
    @(negedge clk);
    to_reset = 1'b0;
    cycles(2);
    chk("to_mid_req", {31'd0, to_req}, 32'd1);
    to_reset = 1'b1;
    #1;
    chk("to_mid_rst_req", {31'd0, to_req}, 32'd0);
    chk("to_mid_rst_pc", to_pc, 32'h40);

    // Random programs against the model
    for (int p = 0; p < 6; p++) begin
      clear_prog();
      for (int i = 0; i < 24; i++) prog[i] = gen_instr();
      m_reset();
      for (int i = 0; i < 24; i++) m_step();
      do_reset();
      cycles(m_cyc);
      chk($sformatf("rnd%0d_pc", p), pc, m_pc);
      chk($sformatf("rnd%0d_req", p), {31'd0, mem_req}, 32'd1);
      chk($sformatf("rnd%0d_addr", p), mem_addr, m_pc);
      chk($sformatf("rnd%0d_halt", p), {31'd0, halted}, 32'd0);
      for (int i = 0; i < 15; i++) chk($sformatf("rnd%0d_r%0d", p, i), leds[i], m_r[i]);
      for (int i = 0; i < 256; i++) begin
        if (ram[i] !== m_mem[i]) chk($sformatf("rnd%0d_ram%0d", p, i), ram[i], m_mem[i]);
      end
      checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
